// File: rtl/tm_inference_sequencer.sv
// Frame-level controller for the Tsetlin-machine inference core: counts S00 beats into packet
// indices, starts the core once per full datapoint and presents the captured class on M00.
module tm_inference_sequencer #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 64,
    parameter int C_M00_AXIS_TDATA_WIDTH = 64,
    parameter int FEATURE_NUM            = 784,
    parameter int PACKETS_NUM            = (FEATURE_NUM - 1) / C_S00_AXIS_TDATA_WIDTH + 1,
    parameter int CNT_W                  = 8
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_aresetn,
    input  logic                                  s_axis_tvalid,
    input  logic                                  s_axis_tlast,
    output logic                                  s_axis_tready,
    output logic                                  core_load,
    output logic [CNT_W-1:0]                      packet_counter,
    output logic                                  core_start,
    input  logic                                  core_finish,
    input  logic [C_M00_AXIS_TDATA_WIDTH-1:0]     core_y,
    input  logic                                  m00_axis_tready,
    output logic                                  m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tkeep,
    output logic                                  m00_axis_tlast,
    input  logic                                  err_clr,
    output logic [1:0]                            err_status,
    output logic [31:0]                           frame_count
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PACKETS_NUM - 1);

    typedef enum logic [1:0] {ST_LOAD, ST_WAIT, ST_OUT} state_t;

    state_t                              state_q, state_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic                                start_q, start_d;
    logic                                valid_q, valid_d;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0]   data_q, data_d;
    logic                                tlast_q, tlast_d;
    logic                                last_flag_q, last_flag_d;
    logic [1:0]                          err_q, err_d;
    logic [31:0]                         frames_q, frames_d;

    // Ready depends only on state, so there is no path from m00_axis_tready to s_axis_tready.
    assign s_axis_tready   = (state_q == ST_LOAD);
    assign core_load       = s_axis_tvalid & s_axis_tready;
    assign packet_counter  = cnt_q;
    assign core_start      = start_q;
    assign m00_axis_tvalid = valid_q;
    assign m00_axis_tdata  = data_q;
    assign m00_axis_tkeep  = {(C_M00_AXIS_TDATA_WIDTH/8){valid_q}};
    assign m00_axis_tlast  = tlast_q;
    assign err_status      = err_q;
    assign frame_count     = frames_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        start_d     = 1'b0;
        valid_d     = valid_q;
        data_d      = data_q;
        tlast_d     = tlast_q;
        last_flag_d = last_flag_q;
        frames_d    = frames_q;
        // Clear first so that a set event in the same cycle overrides it.
        err_d       = err_clr ? 2'b00 : err_q;

        case (state_q)
            ST_LOAD: begin
                if (core_finish) begin
                    err_d[1] = 1'b1;
                end
                if (core_load) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d       = '0;
                        last_flag_d = s_axis_tlast;
                        start_d     = 1'b1;
                        state_d     = ST_WAIT;
                    end else if (s_axis_tlast) begin
                        cnt_d    = '0;
                        err_d[0] = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (core_finish) begin
                    data_d  = core_y;
                    tlast_d = last_flag_q;
                    valid_d = 1'b1;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (core_finish) begin
                    err_d[1] = 1'b1;
                end
                if (m00_axis_tready) begin
                    valid_d  = 1'b0;
                    tlast_d  = 1'b0;
                    frames_d = frames_q + 32'd1;
                    state_d  = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            tlast_q     <= 1'b0;
            last_flag_q <= 1'b0;
            err_q       <= 2'b00;
            frames_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_q     <= start_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            tlast_q     <= tlast_d;
            last_flag_q <= last_flag_d;
            err_q       <= err_d;
            frames_q    <= frames_d;
        end
    end

endmodule

// File: tb/tb_tm_inference_sequencer.sv
// Scoreboard bench for tm_inference_sequencer: a frame-level model predicts results and errors,
// a core model answers core_start, and a monitor checks every M00 handshake against the queue.
module tb_tm_inference_sequencer;

    localparam int DW   = 64;
    localparam int CW   = 8;
    localparam int PKTS = (784 - 1) / 64 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            aresetn, sTvalid, sTlast, sTready, coreLoad, coreStart, coreFinish;
    logic            mTready, mTvalid, mTlast, errClr;
    logic [CW-1:0]   packetCounter;
    logic [DW-1:0]   coreY, mTdata;
    logic [DW/8-1:0] mTkeep;
    logic [1:0]      errStatus;
    logic [31:0]     frameCount;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t        expQ[$];
    logic        frameTlastQ[$];
    exp_t        item;
    int          checks = 0, errors = 0;
    int          beatIdx = 0, expStarts = 0, startsSeen = 0, expFrames = 0;
    logic [1:0]  expErr = 2'b00;
    int          coreDelay = 4, readyMode = 0, spurReq = 0, spurDone = 0, countdown = 0;
    logic        sStart, sRst, prevStart = 1'b0, lastFlag;
    logic        prevHold = 1'b0, prevHandshake = 1'b0, holdLast;
    logic [DW-1:0] holdData;

    tm_inference_sequencer dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (aresetn),
        .s_axis_tvalid    (sTvalid),
        .s_axis_tlast     (sTlast),
        .s_axis_tready    (sTready),
        .core_load        (coreLoad),
        .packet_counter   (packetCounter),
        .core_start       (coreStart),
        .core_finish      (coreFinish),
        .core_y           (coreY),
        .m00_axis_tready  (mTready),
        .m00_axis_tvalid  (mTvalid),
        .m00_axis_tdata   (mTdata),
        .m00_axis_tkeep   (mTkeep),
        .m00_axis_tlast   (mTlast),
        .err_clr          (errClr),
        .err_status       (errStatus),
        .frame_count      (frameCount)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired at %0t", name, $time);
    endtask

    // One beat, held until accepted; the frame model advances only on acceptance.
    task automatic applyStimulus(input logic last, input logic clr);
        bit ok = 0;
        sTvalid = 1'b1;
        sTlast  = last;
        errClr  = clr;
        for (int w = 0; w < 500; w++) begin
            @(negedge clk);
            if (sTready) begin
                ok = 1;
                break;
            end
        end
        if (ok) checkOutput("packet_counter", 64'(packetCounter), 64'(beatIdx));
        else reportTimeout("beat_accept");
        @(posedge clk);
        #1;
        sTvalid = 1'b0;
        sTlast  = 1'b0;
        errClr  = 1'b0;
        if (ok) begin
            if (clr) expErr = 2'b00;
            if (beatIdx == PKTS - 1) begin
                frameTlastQ.push_back(last);
                expStarts++;
                beatIdx = 0;
            end else if (last) begin
                expErr[0] = 1'b1;
                beatIdx   = 0;
            end else begin
                beatIdx++;
            end
        end
    endtask

    task automatic sendFrame(input int nBeats, input logic lastOnFinal, input logic clrOnFinal,
                             input int maxGap);
        for (int i = 0; i < nBeats; i++) begin
            int g = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
            applyStimulus(lastOnFinal && (i == nBeats - 1), clrOnFinal && (i == nBeats - 1));
        end
    endtask

    task automatic doReset();
        aresetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_tvalid",  64'(mTvalid),       64'd0);
        checkOutput("rst_tkeep",   64'(mTkeep),        64'd0);
        checkOutput("rst_tdata",   mTdata,             64'd0);
        checkOutput("rst_tlast",   64'(mTlast),        64'd0);
        checkOutput("rst_err",     64'(errStatus),     64'd0);
        checkOutput("rst_frames",  64'(frameCount),    64'd0);
        checkOutput("rst_counter", 64'(packetCounter), 64'd0);
        checkOutput("rst_start",   64'(coreStart),     64'd0);
        checkOutput("rst_s_ready", 64'(sTready),       64'd1);
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        beatIdx = 0;
        frameTlastQ.delete();
        expErr = 2'b00;
    endtask

    task automatic waitIdle();
        bit done = 0;
        for (int w = 0; w < 1000; w++) begin
            @(negedge clk);
            #2;
            if (expQ.size() == 0 && frameTlastQ.size() == 0 && !mTvalid && countdown == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) reportTimeout("wait_idle");
    endtask

    task automatic waitResult();
        bit seen = 0;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (mTvalid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) reportTimeout("wait_result");
    endtask

    // Downstream ready: always high, random, or held low.
    initial begin
        mTready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       mTready = 1'b1;
                1:       mTready = 1'($urandom_range(0, 1));
                default: mTready = 1'b0;
            endcase
        end
    end

    // Core model: answers each start after coreDelay cycles with a random class word.
    initial begin
        coreFinish = 1'b0;
        coreY      = '0;
        forever begin
            @(negedge clk);
            sStart = coreStart;
            sRst   = !aresetn;
            if (!sRst && sStart) begin
                startsSeen++;
                checkOutput("core_start_pulse",  64'(prevStart), 64'd0);
                checkOutput("start_while_valid", 64'(mTvalid),   64'd0);
            end
            prevStart = sStart && !sRst;
            @(posedge clk);
            #1;
            coreFinish = 1'b0;
            if (sRst) begin
                countdown = 0;
            end else if (sStart) begin
                countdown = coreDelay;
            end else if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    coreFinish = 1'b1;
                    coreY      = {$urandom, $urandom};
                    lastFlag   = (frameTlastQ.size() > 0) ? frameTlastQ.pop_front() : 1'b0;
                    expQ.push_back('{coreY, lastFlag});
                end
            end else if (spurReq != spurDone) begin
                coreFinish = 1'b1;
                coreY      = {$urandom, $urandom};
                spurDone++;
            end
        end
    end

    // Monitor: pops the scoreboard on each M00 handshake and checks hold/ready rules.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("frame_count", 64'(frameCount), 64'(expFrames));
            if (!mTvalid) checkOutput("tkeep_idle", 64'(mTkeep), 64'd0);
            else checkOutput("s_ready_while_valid", 64'(sTready), 64'd0);
            if (prevHandshake) checkOutput("s_ready_after_handshake", 64'(sTready), 64'd1);
            if (prevHold) begin
                checkOutput("tvalid_hold", 64'(mTvalid), 64'd1);
                checkOutput("tdata_hold",  mTdata,       holdData);
                checkOutput("tlast_hold",  64'(mTlast),  64'(holdLast));
            end
            prevHold      = 1'b0;
            prevHandshake = 1'b0;
            if (!aresetn) begin
                expQ.delete();
                expFrames = 0;
            end else if (mTvalid) begin
                if (mTready) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_result: actual tdata=%0h required no result at %0t",
                                 mTdata, $time);
                    end else begin
                        item = expQ.pop_front();
                        checkOutput("tdata", mTdata,       item.data);
                        checkOutput("tlast", 64'(mTlast),  64'(item.last));
                        checkOutput("tkeep", 64'(mTkeep),  64'hFF);
                    end
                    expFrames++;
                    prevHandshake = 1'b1;
                end else begin
                    prevHold = 1'b1;
                    holdData = mTdata;
                    holdLast = mTlast;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        aresetn = 1'b0;
        sTvalid = 1'b0;
        sTlast  = 1'b0;
        errClr  = 1'b0;
        doReset();

        $display("[TB] single frame with tlast");
        readyMode = 0;
        coreDelay = 4;
        sendFrame(PKTS, 1'b1, 1'b0, 0);
        waitIdle();
        checkOutput("frames_after_first", 64'(frameCount), 64'd1);
        @(posedge clk);
        #1;

        $display("[TB] downstream stall");
        readyMode = 2;
        sendFrame(PKTS, 1'b0, 1'b0, 0);
        waitResult();
        repeat (20) @(posedge clk);
        readyMode = 0;
        #1;
        sendFrame(PKTS, 1'b0, 1'b0, 0);
        waitIdle();
        checkOutput("frames_after_stall", 64'(frameCount), 64'd3);
        @(posedge clk);
        #1;

        $display("[TB] spurious core_finish in LOAD");
        expErr[1] = 1'b1;
        spurReq++;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (spurDone == spurReq) break;
        end
        @(negedge clk);
        checkOutput("err_spurious",     64'(errStatus), 64'(expErr));
        checkOutput("tvalid_spurious",  64'(mTvalid),   64'd0);
        @(posedge clk);
        #1;

        $display("[TB] short frame with simultaneous clear");
        sendFrame(6, 1'b1, 1'b1, 0);
        @(negedge clk);
        checkOutput("err_short",     64'(errStatus),     64'(expErr));
        checkOutput("counter_short", 64'(packetCounter), 64'd0);
        @(posedge clk);
        #1;
        sendFrame(PKTS, 1'b0, 1'b0, 0);
        waitIdle();
        checkOutput("err_after_good", 64'(errStatus), 64'(expErr));
        @(posedge clk);
        #1;
        errClr = 1'b1;
        @(posedge clk);
        #1;
        errClr = 1'b0;
        expErr = 2'b00;
        @(negedge clk);
        checkOutput("err_cleared", 64'(errStatus), 64'(expErr));
        @(posedge clk);
        #1;

        $display("[TB] reset mid-frame and during OUT");
        sendFrame(7, 1'b0, 1'b0, 0);
        doReset();
        readyMode = 2;
        sendFrame(PKTS, 1'b1, 1'b0, 0);
        waitResult();
        @(posedge clk);
        #1;
        doReset();
        readyMode = 0;

        $display("[TB] three frames with random gaps");
        readyMode = 1;
        coreDelay = int'($urandom_range(1, 8));
        sendFrame(PKTS, 1'b0, 1'b0, 3);
        sendFrame(PKTS, 1'b0, 1'b0, 3);
        sendFrame(PKTS, 1'b1, 1'b0, 3);
        waitIdle();
        checkOutput("frames_after_burst", 64'(frameCount), 64'd3);
        checkOutput("core_start_count",   64'(startsSeen), 64'(expStarts));
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
